// File: rtl/vrf_read_pipe_if.sv
// Request, SRAM read-port and result signals of the VRF read pipe.
// slave is the pipe's view; master is the requester/SRAM/consumer view.
interface vrf_read_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  io_in_ready;
    logic                  io_in_valid;
    logic [4:0]            io_in_bits_vs;
    logic [1:0]            io_in_bits_readSource;
    logic [3:0]            io_in_bits_offset;
    logic [2:0]            io_in_bits_instructionIndex;
    logic                  sram_read_en;
    logic [8:0]            sram_addr;
    logic [DATA_WIDTH-1:0] sram_read_data;
    logic                  io_result_ready;
    logic                  io_result_valid;
    logic [DATA_WIDTH-1:0] io_result_bits_data;
    logic [1:0]            io_result_bits_readSource;
    logic [2:0]            io_result_bits_instructionIndex;

    // Both ports use valid/ready: a transfer happens on a rising clock edge
    // where valid and ready are both high; ready never depends on valid.
    modport slave (
        output io_in_ready,
        input  io_in_valid, io_in_bits_vs, io_in_bits_readSource,
        input  io_in_bits_offset, io_in_bits_instructionIndex,
        output sram_read_en, sram_addr,
        input  sram_read_data,
        input  io_result_ready,
        output io_result_valid, io_result_bits_data,
        output io_result_bits_readSource, io_result_bits_instructionIndex
    );

    modport master (
        input  io_in_ready,
        output io_in_valid, io_in_bits_vs, io_in_bits_readSource,
        output io_in_bits_offset, io_in_bits_instructionIndex,
        input  sram_read_en, sram_addr,
        output sram_read_data,
        output io_result_ready,
        input  io_result_valid, io_result_bits_data,
        input  io_result_bits_readSource, io_result_bits_instructionIndex
    );
endinterface

// File: rtl/vrf_read_pipe.sv
// VRF read pipe: fixed-latency SRAM read with tag pipeline and credit-protected result FIFO.
// Optional perf counters enabled by defining VRF_READ_PIPE_PERF_EN.
module vrf_read_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int RESULT_DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    vrf_read_pipe_if.slave bus
`ifdef VRF_READ_PIPE_PERF_EN
    ,
    output logic [15:0] perf_stall_cycles,
    output logic [15:0] perf_reads
`endif
);
    localparam int OCC_W = $clog2(RESULT_DEPTH + 1);
    localparam int PTR_W = $clog2(RESULT_DEPTH);
    localparam int CRD_W = $clog2(RESULT_DEPTH + READ_LATENCY + 1);

    logic [READ_LATENCY-1:0] tag_valid;
    logic [1:0]              tag_src [READ_LATENCY];
    logic [2:0]              tag_idx [READ_LATENCY];

    logic [DATA_WIDTH-1:0]   fifo_data [RESULT_DEPTH];
    logic [1:0]              fifo_src  [RESULT_DEPTH];
    logic [2:0]              fifo_idx  [RESULT_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [OCC_W-1:0]        occ;

    logic [CRD_W-1:0]        credit_used;
    logic                    fire;
    logic                    wr_en;
    logic                    pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESULT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Every accepted request holds a credit until its result is popped.
    always_comb begin
        credit_used = CRD_W'(occ);
        for (int i = 0; i < READ_LATENCY; i++) begin
            credit_used = credit_used + CRD_W'(tag_valid[i]);
        end
    end

    assign bus.io_in_ready  = credit_used < CRD_W'(RESULT_DEPTH);
    assign fire             = bus.io_in_valid & bus.io_in_ready;
    assign bus.sram_read_en = fire;
    assign bus.sram_addr    = {bus.io_in_bits_vs, bus.io_in_bits_offset};

    assign wr_en = tag_valid[READ_LATENCY-1];
    assign pop   = (occ != '0) & bus.io_result_ready;

    assign bus.io_result_valid                 = occ != '0;
    assign bus.io_result_bits_data             = fifo_data[rd_ptr];
    assign bus.io_result_bits_readSource       = fifo_src[rd_ptr];
    assign bus.io_result_bits_instructionIndex = fifo_idx[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid <= '0;
        end else begin
            tag_valid[0] <= fire;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        tag_src[0] <= bus.io_in_bits_readSource;
        tag_idx[0] <= bus.io_in_bits_instructionIndex;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_src[i] <= tag_src[i-1];
            tag_idx[i] <= tag_idx[i-1];
        end
    end

    // The last tag stage lines up with the SRAM data of the same request.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            fifo_data[wr_ptr] <= bus.sram_read_data;
            fifo_src[wr_ptr]  <= tag_src[READ_LATENCY-1];
            fifo_idx[wr_ptr]  <= tag_idx[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef VRF_READ_PIPE_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_reads        <= '0;
        end else begin
            if (bus.io_in_valid && !bus.io_in_ready && perf_stall_cycles != 16'hFFFF)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (fire && perf_reads != 16'hFFFF)
                perf_reads <= perf_reads + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_vrf_read_pipe.sv
// Randomized bench for vrf_read_pipe: behavioural SRAM plus an in-order
// outstanding-request model predicting ready, latency and result contents.
module tb_vrf_read_pipe;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int D  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vrf_read_pipe_if #(.DATA_WIDTH(DW)) bus ();
`ifdef VRF_READ_PIPE_PERF_EN
    logic [15:0] perf_stall_cycles;
    logic [15:0] perf_reads;
`endif

    vrf_read_pipe #(.DATA_WIDTH(DW), .READ_LATENCY(L), .RESULT_DEPTH(D)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef VRF_READ_PIPE_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_reads(perf_reads)
`endif
    );

    typedef struct packed {
        logic [31:0]   acc;
        logic [DW-1:0] data;
        logic [1:0]    src;
        logic [2:0]    idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [DW-1:0] mem [512];
    logic        sh_v [L];
    logic [8:0]  sh_a [L];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          fire_cnt = 0;
    logic [15:0] m_stall = '0;
    logic [15:0] m_reads = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    // Behavioural SRAM: data for a strobe appears L cycles later, garbage otherwise.
    task automatic drive_sram();
        bus.sram_read_data = sh_v[L-1] ? mem[sh_a[L-1]] : DW'($urandom());
    endtask

    task automatic shift_sram(input logic v, input logic [8:0] a);
        for (int i = L - 1; i > 0; i--) begin
            sh_v[i] = sh_v[i-1];
            sh_a[i] = sh_a[i-1];
        end
        sh_v[0] = v;
        sh_a[0] = a;
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            drive_sram();
            reset = 1'b1;
            bus.io_in_valid = 1'b0;
            bus.io_result_ready = 1'b0;
            shift_sram(1'b0, 9'h0);
            cyc++;
        end
        exp_q.delete();
        m_stall = '0;
        m_reads = '0;
    endtask

    task automatic cycle(input logic v, input logic rr, input logic [4:0] vs,
                         input logic [1:0] src, input logic [3:0] off, input logic [2:0] idx);
        logic exp_rdy;
        logic exp_vld;
        int   buffered;
        exp_t e;
        @(negedge clock);
        reset = 1'b0;
        drive_sram();
        bus.io_in_valid = v;
        bus.io_in_bits_vs = vs;
        bus.io_in_bits_readSource = src;
        bus.io_in_bits_offset = off;
        bus.io_in_bits_instructionIndex = idx;
        bus.io_result_ready = rr;
        #1;
        exp_rdy = exp_q.size() < D;
        check_eq("in_ready", bus.io_in_ready, exp_rdy);
        check_eq("read_en", bus.sram_read_en, v & exp_rdy);
        if (v && exp_rdy) check_eq("sram_addr", bus.sram_addr, {vs, off});
        exp_vld = exp_q.size() > 0 && cyc >= int'(exp_q[0].acc) + L + 1;
        check_eq("result_valid", bus.io_result_valid, exp_vld);
        if (exp_vld && rr) begin
            e = exp_q.pop_front();
            check_eq("result_data", bus.io_result_bits_data, e.data);
            check_eq("result_src", bus.io_result_bits_readSource, e.src);
            check_eq("result_idx", bus.io_result_bits_instructionIndex, e.idx);
        end
`ifdef VRF_READ_PIPE_PERF_EN
        check_eq("perf_stall", perf_stall_cycles, m_stall);
        check_eq("perf_reads", perf_reads, m_reads);
        if (v && !exp_rdy && m_stall != 16'hFFFF) m_stall++;
        if (v && exp_rdy && m_reads != 16'hFFFF) m_reads++;
`endif
        if (v && bus.io_in_ready) begin
            e.acc  = cyc;
            e.data = mem[{vs, off}];
            e.src  = src;
            e.idx  = idx;
            exp_q.push_back(e);
            fire_cnt++;
        end
        buffered = 0;
        foreach (exp_q[i]) if (cyc >= int'(exp_q[i].acc) + L) buffered++;
        check_eq("no_overflow", buffered <= D, 1'b1);
        shift_sram(bus.sram_read_en, bus.sram_addr);
        cyc++;
    endtask

    task automatic cycle_rand(input logic v, input logic rr);
        cycle(v, rr, 5'($urandom()), 2'($urandom()), 4'($urandom()), 3'($urandom()));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = DW'($urandom());
        mem[9'h053] = 32'hDEADBEEF;
        for (int i = 0; i < L; i++) begin
            sh_v[i] = 1'b0;
            sh_a[i] = 9'h0;
        end
        bus.io_in_valid = 1'b0;
        bus.io_in_bits_vs = '0;
        bus.io_in_bits_readSource = '0;
        bus.io_in_bits_offset = '0;
        bus.io_in_bits_instructionIndex = '0;
        bus.io_result_ready = 1'b0;
        bus.sram_read_data = '0;

        do_reset(2);
        cycle(1'b1, 1'b1, 5'd5, 2'd2, 4'd3, 3'd6);
        for (int i = 0; i < 6; i++) cycle_rand(1'b0, 1'b1);

        for (int i = 0; i < 16; i++) cycle_rand(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle_rand(1'b0, 1'b1);

        // Back-pressure: 4 accepts then 10 stalled cycles.
        do_reset(1);
        fire_cnt = 0;
        for (int i = 0; i < 14; i++) cycle_rand(1'b1, 1'b0);
        cycle_rand(1'b0, 1'b0);
        check_eq("bp_accepts", fire_cnt, 4);
`ifdef VRF_READ_PIPE_PERF_EN
        check_eq("bp_perf_stall", perf_stall_cycles, 16'd10);
        check_eq("bp_perf_reads", perf_reads, 16'd4);
`endif
        for (int i = 0; i < 8; i++) cycle_rand(1'b0, 1'b1);

        for (int i = 0; i < 400; i++)
            cycle_rand($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

        // Reset with requests in flight and results buffered; late data must be dropped.
        for (int i = 0; i < 6; i++) cycle_rand(1'b1, 1'b0);
        do_reset(1);
        for (int i = 0; i < 6; i++) cycle_rand(1'b0, 1'b1);

        for (int i = 0; i < 200; i++)
            cycle_rand($urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
